// File: rtl/key_pkg.sv
// Shared constants for the key front-end: idle/pressed levels and default
// filter lengths derived from the system clock rate.
package key_pkg;

  localparam logic KEY_IDLE    = 1'b1;
  localparam logic KEY_PRESSED = 1'b0;

  localparam int CLK_FREQ_HZ      = 50_000_000;
  localparam int DEBOUNCE_CNT_DEF = CLK_FREQ_HZ / 50;  // 20 ms
  localparam int LONG_CNT_DEF     = CLK_FREQ_HZ;       // 1 s

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, stability counter, debounced level and
// press/release strobes. KEY_LONG_PRESS_EN adds a hold counter and key_long.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
`ifdef KEY_LONG_PRESS_EN
  ,
  parameter int LONG_CNT     = LONG_CNT_DEF
`endif
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_raw,
  output logic key_db,
  output logic key_press,
  output logic key_release
`ifdef KEY_LONG_PRESS_EN
  ,
  output logic key_long
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CNT);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Stage p0/p1: synchroniser, the only flops that see key_raw
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sync_p0 <= KEY_IDLE;
      sync_p1 <= KEY_IDLE;
    end else begin
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Filter stage: accept a new level only after DEBOUNCE_CNT unbroken cycles
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt         <= '0;
      key_db      <= KEY_IDLE;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      if (sync_p1 == key_db) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CNT - 1)) begin
        cnt         <= '0;
        key_db      <= sync_p1;
        key_press   <= (sync_p1 == KEY_PRESSED);
        key_release <= (sync_p1 == KEY_IDLE);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_CNT);

  logic [LONG_W-1:0] hold_cnt;
  logic              hold_done;

  // Hold stage: one key_long pulse per press, counter parks until release
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      hold_cnt  <= '0;
      hold_done <= 1'b0;
      key_long  <= 1'b0;
    end else begin
      key_long <= 1'b0;
      if (key_db == KEY_IDLE) begin
        hold_cnt  <= '0;
        hold_done <= 1'b0;
      end else if (!hold_done) begin
        if (hold_cnt == LONG_W'(LONG_CNT - 1)) begin
          key_long  <= 1'b1;
          hold_done <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: rtl/key_debounce.sv
// Push-button front end: KEY_NUM independent debounce channels producing a clean
// active-low key vector plus strobes. Define KEY_LONG_PRESS_EN for key_long.
module key_debounce
  import key_pkg::*;
#(
  parameter int KEY_NUM      = 2,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
`ifdef KEY_LONG_PRESS_EN
  ,
  parameter int LONG_CNT     = LONG_CNT_DEF
`endif
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [KEY_NUM-1:0] keys_raw,
  output logic [KEY_NUM-1:0] keys_db,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release
`ifdef KEY_LONG_PRESS_EN
  ,
  output logic [KEY_NUM-1:0] key_long
`endif
);

  if (DEBOUNCE_CNT < 2) begin : g_bad_cnt
    $error("key_debounce: DEBOUNCE_CNT must be at least 2");
  end

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
`ifdef KEY_LONG_PRESS_EN
      ,
      .LONG_CNT     (LONG_CNT)
`endif
    ) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .key_raw     (keys_raw[i]),
      .key_db      (keys_db[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i])
`ifdef KEY_LONG_PRESS_EN
      ,
      .key_long    (key_long[i])
`endif
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (DEBOUNCE_CNT=8, LONG_CNT=40) with a
// window-based reference model compared every cycle plus literal spot checks.
module tb_key_debounce;

  localparam int D    = 8;
  localparam int LONG = 40;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic [1:0] keys_raw = 2'b00;
  logic [1:0] keys_db;
  logic [1:0] key_press;
  logic [1:0] key_release;
`ifdef KEY_LONG_PRESS_EN
  logic [1:0] key_long;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  key_debounce #(
    .KEY_NUM      (2),
    .DEBOUNCE_CNT (D)
`ifdef KEY_LONG_PRESS_EN
    ,
    .LONG_CNT     (LONG)
`endif
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .keys_raw    (keys_raw),
    .keys_db     (keys_db),
    .key_press   (key_press),
    .key_release (key_release)
`ifdef KEY_LONG_PRESS_EN
    ,
    .key_long    (key_long)
`endif
  );

  // Reference model: a level is accepted once the synchronised key has
  // disagreed with the current level for the last D samples in a row.
  logic [1:0] m_db, m_press, m_release, m_long, m_s1;
  logic [1:0] hist [D];
  int         fall_cyc [2];
  int         cyc = 0;

  always @(posedge sys_clk or negedge sys_rst) begin : model
    logic [1:0] n_db, n_press, n_rel, n_long;
    logic       all_diff;
    if (!sys_rst) begin
      m_db      <= 2'b11;
      m_press   <= 2'b00;
      m_release <= 2'b00;
      m_long    <= 2'b00;
      m_s1      <= 2'b11;
      for (int j = 0; j < D; j++) hist[j] <= 2'b11;
      for (int k = 0; k < 2; k++) fall_cyc[k] <= -1000;
    end else begin
      n_db    = m_db;
      n_press = 2'b00;
      n_rel   = 2'b00;
      n_long  = 2'b00;
      for (int k = 0; k < 2; k++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++)
          if (hist[j][k] == m_db[k]) all_diff = 1'b0;
        n_long[k] = (m_db[k] == 1'b0) && (cyc + 1 - fall_cyc[k] == LONG);
        if (all_diff) begin
          n_db[k] = ~m_db[k];
          if (n_db[k] == 1'b0) begin
            n_press[k]  = 1'b1;
            fall_cyc[k] <= cyc + 1;
          end else begin
            n_rel[k] = 1'b1;
          end
        end
      end
      m_db      <= n_db;
      m_press   <= n_press;
      m_release <= n_rel;
      m_long    <= n_long;
      for (int j = D - 1; j > 0; j--) hist[j] <= hist[j-1];
      hist[0] <= m_s1;
      m_s1    <= keys_raw;
      cyc     <= cyc + 1;
    end
  end

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    check("model keys_db", keys_db, m_db);
    check("model key_press", key_press, m_press);
    check("model key_release", key_release, m_release);
`ifdef KEY_LONG_PRESS_EN
    check("model key_long", key_long, m_long);
`endif
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  initial begin
    // Reset with both keys held down
    #1 sys_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("rst keys_db", keys_db, 2'b11);
      check("rst strobes", key_press | key_release, 2'b00);
    end
    sys_rst = 1'b1;
    tick(9);
    check("post-rst db c9", keys_db, 2'b11);
    tick(1);
    check("post-rst db c10", keys_db, 2'b00);
    check("post-rst press", key_press, 2'b11);
    tick(1);
    check("post-rst press off", key_press, 2'b00);

    // Release both, then a clean press on key0
    keys_raw = 2'b11;
    tick(12);
    check("released db", keys_db, 2'b11);
    keys_raw = 2'b10;
    tick(9);
    check("clean db T+9", keys_db, 2'b11);
    tick(1);
    check("clean db T+10", keys_db, 2'b10);
    check("clean press", key_press, 2'b01);
    check("clean release", key_release, 2'b00);
    tick(1);
    check("clean press off", key_press, 2'b00);

    // Bounce rejection on key0
    keys_raw = 2'b11;
    tick(12);
    keys_raw = 2'b10; tick(5);
    keys_raw = 2'b11; tick(2);
    keys_raw = 2'b10; tick(7);
    keys_raw = 2'b11; tick(15);
    check("bounce db", keys_db, 2'b11);

    // Release after bounce on key0
    keys_raw = 2'b10; tick(12);
    check("held db", keys_db, 2'b10);
    keys_raw = 2'b11; tick(3);
    keys_raw = 2'b10; tick(2);
    keys_raw = 2'b11; tick(4);
    keys_raw = 2'b10; tick(1);
    keys_raw = 2'b11; tick(5);
    keys_raw = 2'b10; tick(3);
    check("bounce-rel db", keys_db, 2'b10);
    keys_raw = 2'b11;
    tick(9);
    check("settle rel c9", key_release, 2'b00);
    tick(1);
    check("settle rel c10", key_release, 2'b01);
    check("settle db", keys_db, 2'b11);

    // Simultaneous press, then key1 released alone
    tick(2);
    keys_raw = 2'b00;
    tick(9);
    check("simul db c9", keys_db, 2'b11);
    tick(1);
    check("simul db c10", keys_db, 2'b00);
    check("simul press", key_press, 2'b11);
    tick(2);
    keys_raw = 2'b10;
    tick(10);
    check("k1 release", key_release, 2'b10);
    check("k1 db", keys_db, 2'b10);

    // Mid-count reset discards the pending release of key0
    keys_raw = 2'b11;
    tick(5);
    #2 sys_rst = 1'b0;
    #1 check("midrst db", keys_db, 2'b11);
    check("midrst strobes", key_press | key_release, 2'b00);
    tick(2);
    sys_rst = 1'b1;
    tick(12);
    check("after midrst db", keys_db, 2'b11);

`ifdef KEY_LONG_PRESS_EN
    // Long hold on key1: one pulse 40 cycles after acceptance
    keys_raw = 2'b01;
    tick(10);
    check("long db", keys_db, 2'b01);
    tick(39);
    check("long c39", key_long, 2'b00);
    tick(1);
    check("long c40", key_long, 2'b10);
    tick(1);
    check("long c41", key_long, 2'b00);
    tick(19);
    keys_raw = 2'b11;
    tick(12);
    // Short hold: level low for 30 cycles, no long pulse
    keys_raw = 2'b01;
    tick(10);
    tick(20);
    keys_raw = 2'b11;
    tick(15);
    check("short hold long", key_long, 2'b00);
    check("short hold db", keys_db, 2'b11);
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Front-end stage for the push-button inputs.
- Synchronises the raw, bouncing, active-low board keys to sys_clk and filters each key independently.
- Outputs a clean, stable key vector that feeds the LED control stage's keys input directly, plus one-cycle press/release strobes for any other consumer.
- Idle-high convention is preserved end to end: 1 = released, 0 = pressed.

Parameters:
- KEY_NUM, 2, number of independent key channels.
- DEBOUNCE_CNT, 1000000, stable cycles required before accepting a new level (20 ms at 50 MHz); must be >= 2.
- CNT_W, $clog2(DEBOUNCE_CNT), counter width; derived, not overridden.

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst  input  1  asynchronous active-low reset.
- keys_raw  input  KEY_NUM  raw board keys, asynchronous, active-low, bouncing.
- keys_db  output  KEY_NUM  debounced level, active-low; connects to the LED stage's keys.
- key_press  output  KEY_NUM  one-cycle strobe on an accepted 1->0 transition.
- key_release  output  KEY_NUM  one-cycle strobe on an accepted 0->1 transition.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst is asynchronous and active-low. All flops use posedge sys_clk or negedge sys_rst.
- Reset values:
  - Synchroniser flops and keys_db: all 1s (released).
  - Counters: 0.
  - key_press and key_release: 0.
- Synchroniser: 2 flops per key; sync = second stage. Input-to-sync latency is 2 cycles.
- Per-channel filter, one counter per key:
  - sync == keys_db[i]: cnt <= 0.
  - sync != keys_db[i] and cnt < DEBOUNCE_CNT-1: cnt <= cnt+1.
  - sync != keys_db[i] and cnt == DEBOUNCE_CNT-1: keys_db[i] <= sync, cnt <= 0.
- Acceptance latency: a clean edge on keys_raw appears on keys_db exactly 2 + DEBOUNCE_CNT cycles later.
- Glitch rejection: any return of sync to keys_db[i] before the count completes resets cnt to 0, and no output changes. Pulses shorter than DEBOUNCE_CNT cycles are fully rejected.
- Strobes:
  - Registered, asserted in the same cycle keys_db[i] changes, high for exactly 1 cycle.
  - key_press[i] and key_release[i] are never both high.
- Channels are fully independent. Simultaneous edges on several keys are each accepted on their own schedule, so both bits may update in the same cycle.
- Counter never wraps: it saturates into the acceptance condition and then clears.
- Reset mid-count: state is discarded immediately. After reset release, a key held low is accepted as pressed 2 + DEBOUNCE_CNT cycles later, with a key_press strobe.
- Only the two synchroniser flops ever sample keys_raw; no combinational path from keys_raw to any output.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN.
- Enabled:
  - Adds parameter LONG_CNT, default 50000000 (1 s).
  - Adds output key_long, width KEY_NUM.
  - A per-key hold counter runs while keys_db[i] == 0. When it reaches LONG_CNT-1, key_long[i] pulses for 1 cycle, and the counter holds until release, so there is one pulse per press.
  - Release or reset clears the hold counter; key_long resets to 0.
- Disabled: no key_long port, no hold counters. Behaviour is otherwise identical.

Decomposition:
- Shared package key_pkg holds:
  - KEY_IDLE = 1'b1 and KEY_PRESSED = 1'b0 constants.
  - Default DEBOUNCE_CNT and LONG_CNT values derived from a CLK_FREQ_HZ = 50000000 constant.
- Sub-module key_debounce_ch: one channel containing synchroniser, counter, level register, strobes, and the optional hold counter. The top instantiates KEY_NUM copies via generate.

Test Plan:
All scenarios run with DEBOUNCE_CNT = 8 (LONG_CNT = 40 for the last one).
- Reset: assert sys_rst=0 with keys_raw=2'b00 -> keys_db=2'b11 and strobes 0 throughout reset. After release, keys_db=2'b00 at cycle 10, key_press=2'b11 for 1 cycle.
- Clean press on key0: keys_raw 2'b11->2'b10 at cycle T -> keys_db=2'b10 at T+10, key_press=2'b01 for exactly 1 cycle, key_release stays 0.
- Bounce rejection: key0 toggled low for 5 cycles, high for 2, low for 7, then high -> keys_db stays 2'b11, no strobes.
- Release after bounce: key0 held low, then bounces 3 times (< 8 cycles each) before settling high -> key_release=2'b01 exactly 10 cycles after the final settle.
- Simultaneous/independent: both keys pressed in the same cycle -> keys_db 2'b11->2'b00 in one cycle, key_press=2'b11. Then key1 released alone -> only key_release[1] pulses. Mid-count sys_rst pulse -> counts discarded, outputs back to 2'b11.
- KEY_LONG_PRESS_EN: hold key1 for 60 cycles after acceptance -> key_long=2'b10 once, 40 cycles after keys_db[1] falls. Releasing at 30 cycles -> no key_long.
